// File: rtl/dir_input_queue.sv
// Turn queue between the direction-button debouncers and the snake game-state logic.
// Latency: a pushed press shows in o_count one cycle later; a tick moves the head to o_dir in one cycle. The queue never stalls: a full queue drops the press and pulses o_drop.

module dir_fifo #(
   parameter int W     = 2,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop,
   output logic [W-1:0]               head_dat,
   output logic [W-1:0]               last_dat,
   output logic [$clog2(DEPTH):0]     count
);
   // Small circular FIFO that also exposes its most recently written entry.
   // Zero-latency read of head and tail; the owner guarantees push only when not full or when popping.

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] last_ptr;

   assign last_ptr = wr_ptr - PW'(1);
   assign head_dat = mem[rd_ptr];
   assign last_dat = mem[last_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   // Storage is reset too so an unwritten slot never reads as X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push && !clr) begin
         mem[wr_ptr] <= push_dat;
      end
   end

endmodule

// Filters illegal turns, queues legal ones and releases one per game tick.
// Latency: 1 cycle press-to-count and tick-to-o_dir; no backpressure, a full queue drops the press and pulses o_drop.

module dir_input_queue #(
   parameter int         DEPTH    = 4,
   parameter logic [1:0] INIT_DIR = 2'd3
) (
   input  logic                       clk,
   input  logic                       i_rst_n,
   input  logic                       i_up_dn,
   input  logic                       i_down_dn,
   input  logic                       i_left_dn,
   input  logic                       i_right_dn,
   input  logic                       i_tick,
   input  logic                       i_clear,
   output logic [1:0]                 o_dir,
   output logic                       o_turn,
   output logic                       o_drop,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_empty
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic           press_vld;
   logic [1:0]     press_dir;
   logic [1:0]     ref_dir;
   logic [1:0]     opp_dir;
   logic           legal;
   logic           q_empty;
   logic           q_full;
   logic           push;
   logic           pop;
   logic           drop_nxt;
   logic [1:0]     head_dat;
   logic [1:0]     last_dat;
   logic [CW-1:0]  count;
   logic [1:0]     dir_q;
   logic           turn_q;
   logic           drop_q;

   assign press_vld = i_up_dn | i_down_dn | i_left_dn | i_right_dn;

   always_comb begin
      press_dir = 2'd3;
      if (i_up_dn) begin
         press_dir = 2'd0;
      end else if (i_down_dn) begin
         press_dir = 2'd1;
      end else if (i_left_dn) begin
         press_dir = 2'd2;
      end
   end

   // Legality is judged against where the snake will be heading once everything queued has been applied.
   assign q_empty  = (count == '0);
   assign q_full   = (count == CW'(DEPTH));
   assign ref_dir  = q_empty ? dir_q : last_dat;
   assign opp_dir  = {ref_dir[1], ~ref_dir[0]};
   assign legal    = press_vld && (press_dir != ref_dir) && (press_dir != opp_dir);

   assign pop      = i_tick && !q_empty && !i_clear;
   assign push     = legal && (!q_full || pop) && !i_clear;
   assign drop_nxt = legal && q_full && !pop && !i_clear;

   dir_fifo #(
      .W     (2),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (i_rst_n),
      .clr      (i_clear),
      .push     (push),
      .push_dat (press_dir),
      .pop      (pop),
      .head_dat (head_dat),
      .last_dat (last_dat),
      .count    (count)
   );

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dir_q  <= INIT_DIR;
         turn_q <= 1'b0;
         drop_q <= 1'b0;
      end else if (i_clear) begin
         dir_q  <= INIT_DIR;
         turn_q <= 1'b0;
         drop_q <= 1'b0;
      end else begin
         turn_q <= pop;
         drop_q <= drop_nxt;
         if (pop) begin
            dir_q <= head_dat;
         end
      end
   end

   assign o_dir   = dir_q;
   assign o_turn  = turn_q;
   assign o_drop  = drop_q;
   assign o_count = count;
   assign o_empty = q_empty;

endmodule
